// File: rtl/life_engine.sv
// life_engine: Game-of-Life engine holding a COLS x ROWS grid and computing one row per clock.
// Define LIFE_WRAP_EN for a toroidal grid; by default cells beyond the border read as dead.
module life_engine #(
    parameter int          COLS      = 32,
    parameter int          ROWS      = 24,
    parameter int          GEN_W     = 13,
    parameter logic [31:0] SEED_INIT = 32'hACE1_2F5B,
    localparam int         X_W       = $clog2(COLS),
    localparam int         Y_W       = $clog2(ROWS),
    localparam int         LC_W      = $clog2(COLS*ROWS+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd,
    output logic             cmd_ready,
    input  logic [X_W-1:0]   cur_x,
    input  logic [Y_W-1:0]   cur_y,
    input  logic [X_W-1:0]   rd_x,
    input  logic [Y_W-1:0]   rd_y,
    output logic             rd_cell,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] generation,
    output logic [LC_W-1:0]  live_count
);

    localparam logic [2:0]     CMD_STEP   = 3'd1;
    localparam logic [2:0]     CMD_CLEAR  = 3'd2;
    localparam logic [2:0]     CMD_TOGGLE = 3'd3;
    localparam logic [2:0]     CMD_SEED   = 3'd4;
    localparam logic [31:0]    LFSR_TAPS  = 32'h8020_0003;
    localparam logic [X_W:0]   COLS_LIM   = (X_W+1)'(COLS);
    localparam logic [Y_W:0]   ROWS_LIM   = (Y_W+1)'(ROWS);
    localparam logic [Y_W-1:0] LAST_ROW   = Y_W'(ROWS-1);

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_SEED} state_e;

    state_e           state_q, state_d;
    logic [Y_W-1:0]   row_q, row_d;
    logic [COLS-1:0]  grid_q [ROWS];
    logic [COLS-1:0]  grid_d [ROWS];
    logic [COLS-1:0]  prev_old_q, prev_old_d;
`ifdef LIFE_WRAP_EN
    logic [COLS-1:0]  first_old_q, first_old_d;
`endif
    logic [LC_W-1:0]  acc_q, acc_d, live_q, live_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic             done_q, done_d, rd_cell_q, rd_cell_d;

    logic             last_row, cur_ok, rd_ok, cur_cell;
    logic [Y_W-1:0]   row_nxt;
    logic [COLS-1:0]  row_above, row_cur, row_below, new_row, seed_row, sweep_row;
    logic [COLS+1:0]  ext_above, ext_centre, ext_below;
    logic [3:0]       nbr;
    logic [LC_W-1:0]  pop_row;
    logic [31:0]      lfsr_next;

    function automatic logic [LC_W-1:0] popcount(input logic [COLS-1:0] v);
        popcount = '0;
        for (int i = 0; i < COLS; i++) popcount = popcount + LC_W'(v[i]);
    endfunction

    assign last_row  = (row_q == LAST_ROW);
    assign row_nxt   = last_row ? '0 : row_q + 1'b1;
    assign cur_ok    = ({1'b0, cur_x} < COLS_LIM) && ({1'b0, cur_y} < ROWS_LIM);
    assign rd_ok     = ({1'b0, rd_x} < COLS_LIM) && ({1'b0, rd_y} < ROWS_LIM);
    assign cur_cell  = grid_q[cur_y][cur_x];
    assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

    // Neighbourhood of the row being rebuilt; ext_* carry one halo column on each side.
    always_comb begin
        row_cur   = grid_q[row_q];
        row_above = prev_old_q;
        row_below = grid_q[row_nxt];
`ifdef LIFE_WRAP_EN
        if (row_q == '0) row_above = grid_q[LAST_ROW];
        if (last_row)    row_below = first_old_q;
        ext_above  = {row_above[0], row_above, row_above[COLS-1]};
        ext_centre = {row_cur[0],   row_cur,   row_cur[COLS-1]};
        ext_below  = {row_below[0], row_below, row_below[COLS-1]};
`else
        if (row_q == '0) row_above = '0;
        if (last_row)    row_below = '0;
        ext_above  = {1'b0, row_above, 1'b0};
        ext_centre = {1'b0, row_cur,   1'b0};
        ext_below  = {1'b0, row_below, 1'b0};
`endif
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        nbr     = '0;
        new_row = '0;
        for (int c = 0; c < COLS; c++) begin
            nbr = 4'(ext_above[c])  + 4'(ext_above[c+1])  + 4'(ext_above[c+2])
                + 4'(ext_centre[c]) + 4'(ext_centre[c+2])
                + 4'(ext_below[c])  + 4'(ext_below[c+1])  + 4'(ext_below[c+2]);
            new_row[c] = (nbr == 4'd3) || (ext_centre[c+1] && (nbr == 4'd2));
        end
        seed_row = '0;
        for (int c = 0; c < COLS; c++) seed_row[c] = lfsr_q[c % 32];
        sweep_row = (state_q == S_SEED) ? seed_row : new_row;
        pop_row   = popcount(sweep_row);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && (cmd == CMD_STEP))      state_d = S_STEP;
                else if (cmd_valid && (cmd == CMD_SEED)) state_d = S_SEED;
            end
            S_STEP, S_SEED: if (last_row) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
    end

    // Datapath: commands in IDLE, one row per cycle while sweeping.
    always_comb begin
        grid_d     = grid_q;
        row_d      = row_q;
        prev_old_d = prev_old_q;
`ifdef LIFE_WRAP_EN
        first_old_d = first_old_q;
`endif
        acc_d     = acc_q;
        live_d    = live_q;
        gen_d     = gen_q;
        lfsr_d    = lfsr_q;
        done_d    = 1'b0;
        rd_cell_d = rd_ok ? grid_q[rd_y][rd_x] : 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd)
                        CMD_STEP: begin
                            row_d = '0;
                            acc_d = '0;
`ifdef LIFE_WRAP_EN
                            first_old_d = grid_q[0];
`endif
                        end
                        CMD_SEED: begin
                            row_d = '0;
                            acc_d = '0;
                        end
                        CMD_CLEAR: begin
                            grid_d = '{default: '0};
                            gen_d  = '0;
                            live_d = '0;
                        end
                        CMD_TOGGLE: begin
                            if (cur_ok) begin
                                grid_d[cur_y][cur_x] = ~cur_cell;
                                live_d = cur_cell ? live_q - 1'b1 : live_q + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_STEP, S_SEED: begin
                grid_d[row_q] = sweep_row;
                prev_old_d    = row_cur;
                acc_d         = acc_q + pop_row;
                row_d         = row_nxt;
                if (state_q == S_SEED) lfsr_d = lfsr_next;
                if (last_row) begin
                    done_d = 1'b1;
                    live_d = acc_q + pop_row;
                    gen_d  = (state_q == S_STEP) ? gen_q + 1'b1 : '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the grid is a register array, not RAM, so it is reset with everything else.
            grid_q     <= '{default: '0};
            row_q      <= '0;
            prev_old_q <= '0;
`ifdef LIFE_WRAP_EN
            first_old_q <= '0;
`endif
            acc_q      <= '0;
            live_q     <= '0;
            gen_q      <= '0;
            lfsr_q     <= SEED_INIT;
            done_q     <= 1'b0;
            rd_cell_q  <= 1'b0;
        end else begin
            grid_q     <= grid_d;
            row_q      <= row_d;
            prev_old_q <= prev_old_d;
`ifdef LIFE_WRAP_EN
            first_old_q <= first_old_d;
`endif
            acc_q      <= acc_d;
            live_q     <= live_d;
            gen_q      <= gen_d;
            lfsr_q     <= lfsr_d;
            done_q     <= done_d;
            rd_cell_q  <= rd_cell_d;
        end
    end

    assign rd_cell    = rd_cell_q;
    assign done       = done_q;
    assign generation = gen_q;
    assign live_count = live_q;

endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: self-checking bench for life_engine against an array-based Game-of-Life model.
// Builds with or without LIFE_WRAP_EN; the model follows the same macro.
module tb_life_engine;

    localparam int          COLS      = 32;
    localparam int          ROWS      = 24;
    localparam int          GEN_W     = 13;
    localparam logic [31:0] SEED_INIT = 32'hACE1_2F5B;
    localparam int          X_W       = $clog2(COLS);
    localparam int          Y_W       = $clog2(ROWS);
    localparam int          LC_W      = $clog2(COLS*ROWS+1);

    localparam logic [2:0] NOP = 3'd0, STEP = 3'd1, CLEAR = 3'd2, TOGGLE = 3'd3, SEED = 3'd4;

    logic             clk = 1'b0;
    logic             rst, cmd_valid, cmd_ready, rd_cell, busy, done;
    logic [2:0]       cmd;
    logic [X_W-1:0]   cur_x, rd_x;
    logic [Y_W-1:0]   cur_y, rd_y;
    logic [GEN_W-1:0] generation;
    logic [LC_W-1:0]  live_count;

    life_engine #(.COLS(COLS), .ROWS(ROWS), .GEN_W(GEN_W), .SEED_INIT(SEED_INIT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .cur_x(cur_x), .cur_y(cur_y), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell),
        .busy(busy), .done(done), .generation(generation), .live_count(live_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        int         x;
        int         y;
        int         exp_live;
    } vec_t;

    vec_t        vecs [13];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        m_grid     [ROWS][COLS];
    logic        dut_grid   [ROWS][COLS];
    logic        seed1_grid [ROWS][COLS];
    int          m_live, m_gen;
    logic [31:0] m_lfsr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int model_count();
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) n += int'(m_grid[r][c]);
        return n;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_grid[r][c] = 1'b0;
        m_live = 0;
        m_gen  = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_lfsr = SEED_INIT;
    endtask

    task automatic model_step();
        logic nxt [ROWS][COLS];
        int   n, rr, cc;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (dr != 0 || dc != 0) begin
`ifdef LIFE_WRAP_EN
                            rr = (rr + ROWS) % ROWS;
                            cc = (cc + COLS) % COLS;
                            n += int'(m_grid[rr][cc]);
`else
                            if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) n += int'(m_grid[rr][cc]);
`endif
                        end
                    end
                end
                nxt[r][c] = (n == 3) || (m_grid[r][c] && n == 2);
            end
        end
        m_grid = nxt;
        m_gen  = (m_gen + 1) % (1 << GEN_W);
        m_live = model_count();
    endtask

    task automatic model_seed();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) m_grid[r][c] = m_lfsr[c % 32];
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
        end
        m_gen  = 0;
        m_live = model_count();
    endtask

    // ---------------- DUT access ----------------
    task automatic issue(input logic [2:0] op, input int x, input int y);
        cmd       = op;
        cur_x     = X_W'(x);
        cur_y     = Y_W'(y);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd       = NOP;
    endtask

    // Follows a sweep from the cycle after acceptance; optionally fires CLEAR and TOGGLE while busy.
    task automatic wait_sweep(input bit inject);
        int bad = 0;
        for (int i = 0; i < ROWS; i++) begin
            if (!(busy === 1'b1 && cmd_ready === 1'b0 && done === 1'b0)) bad++;
            cmd_valid = 1'b0;
            if (inject && i == 2) begin
                cmd = CLEAR; cmd_valid = 1'b1;
            end else if (inject && i == 5) begin
                cmd = TOGGLE; cur_x = X_W'(5); cur_y = Y_W'(5); cmd_valid = 1'b1;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        cmd       = NOP;
        check("sweep_busy_window", bad, 0);
        check("sweep_done_pulse", done, 1);
        check("sweep_busy_clear", busy, 0);
        check("sweep_ready_back", cmd_ready, 1);
        check("sweep_generation", generation, m_gen);
        check("sweep_live_count", live_count, m_live);
        @(posedge clk); #1;
        check("sweep_done_single", done, 0);
    endtask

    task automatic do_cmd(input logic [2:0] op, input int x, input int y, input bit inject);
        issue(op, x, y);
        case (op)
            STEP:   begin model_step(); wait_sweep(inject); end
            SEED:   begin model_seed(); wait_sweep(1'b0); end
            CLEAR:  model_clear();
            TOGGLE: if (x < COLS && y < ROWS) begin
                m_grid[y][x] = ~m_grid[y][x];
                m_live       = model_count();
            end
            default: ;
        endcase
    endtask

    task automatic read_at(input int x, input int y, output logic v);
        rd_x = X_W'(x);
        rd_y = Y_W'(y);
        @(posedge clk); #1;
        v = rd_cell;
    endtask

    task automatic compare_grid(input string name);
        int   mism = 0;
        logic v;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                read_at(x, y, v);
                dut_grid[y][x] = v;
                if (v !== m_grid[y][x]) mism++;
            end
        end
        check(name, mism, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic v;
        int   diff;

        vecs[0]  = '{TOGGLE, 3, 3, 1};
        vecs[1]  = '{TOGGLE, 3, 3, 0};
        vecs[2]  = '{TOGGLE, 0, 0, 1};
        vecs[3]  = '{TOGGLE, 31, 23, 2};
        vecs[4]  = '{TOGGLE, 2, 30, 2};
        vecs[5]  = '{3'd5, 0, 0, 2};
        vecs[6]  = '{3'd6, 31, 23, 2};
        vecs[7]  = '{3'd7, 0, 0, 2};
        vecs[8]  = '{NOP, 0, 0, 2};
        vecs[9]  = '{CLEAR, 0, 0, 0};
        vecs[10] = '{TOGGLE, 4, 5, 1};
        vecs[11] = '{TOGGLE, 5, 5, 2};
        vecs[12] = '{TOGGLE, 6, 5, 3};

        rst = 1'b1; cmd_valid = 1'b0; cmd = NOP;
        cur_x = '0; cur_y = '0; rd_x = '0; rd_y = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_generation", generation, 0);
        check("reset_live_count", live_count, 0);
        check("reset_rd_cell", rd_cell, 0);
        compare_grid("reset_grid");

        // Idle command table: toggles, out-of-range cursor, reserved opcodes, clear.
        foreach (vecs[i]) begin
            do_cmd(vecs[i].op, vecs[i].x, vecs[i].y, 1'b0);
            check($sformatf("vec%0d_live", i), live_count, vecs[i].exp_live);
            check($sformatf("vec%0d_gen", i), generation, 0);
            check($sformatf("vec%0d_ready", i), cmd_ready, 1);
        end
        compare_grid("table_grid");

        // Blinker: horizontal -> vertical -> horizontal.
        do_cmd(STEP, 0, 0, 1'b0);
        read_at(5, 4, v); check("blinker1_5_4", v, 1);
        read_at(5, 6, v); check("blinker1_5_6", v, 1);
        read_at(4, 5, v); check("blinker1_4_5", v, 0);
        read_at(6, 5, v); check("blinker1_6_5", v, 0);
        check("blinker1_gen", generation, 1);
        compare_grid("blinker1_grid");
        do_cmd(STEP, 0, 0, 1'b0);
        read_at(4, 5, v); check("blinker2_4_5", v, 1);
        read_at(5, 4, v); check("blinker2_5_4", v, 0);
        check("blinker2_gen", generation, 2);
        compare_grid("blinker2_grid");

        // CLEAR and TOGGLE during a sweep must be ignored.
        do_cmd(STEP, 0, 0, 1'b1);
        check("inject_live", live_count, 3);
        compare_grid("inject_grid");

        // Seed, random toggles, random evolution.
        do_cmd(SEED, 0, 0, 1'b0);
        check("seed1_gen", generation, 0);
        compare_grid("seed1_grid");
        seed1_grid = dut_grid;
        read_at(0, ROWS + 2, v);
        check("rd_out_of_range", v, 0);
        for (int i = 0; i < 30; i++) begin
            do_cmd(TOGGLE, $urandom_range(COLS - 1, 0), $urandom_range((1 << Y_W) - 1, 0), 1'b0);
            check("rand_toggle_live", live_count, m_live);
        end
        for (int i = 0; i < 6; i++) begin
            do_cmd(STEP, 0, 0, 1'b0);
            compare_grid("rand_step_grid");
        end
        do_cmd(CLEAR, 0, 0, 1'b0);
        check("clear_live", live_count, 0);
        check("clear_gen", generation, 0);
        do_cmd(SEED, 0, 0, 1'b0);
        compare_grid("seed2_grid");
        diff = 0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                if (dut_grid[y][x] !== seed1_grid[y][x]) diff++;
        check("seed2_differs", diff != 0, 1);

        // Glider from the top-left corner.
        do_cmd(CLEAR, 0, 0, 1'b0);
        do_cmd(TOGGLE, 1, 0, 1'b0);
        do_cmd(TOGGLE, 2, 1, 1'b0);
        do_cmd(TOGGLE, 0, 2, 1'b0);
        do_cmd(TOGGLE, 1, 2, 1'b0);
        do_cmd(TOGGLE, 2, 2, 1'b0);
        check("glider_init_live", live_count, 5);
        for (int i = 0; i < 4 * COLS; i++) do_cmd(STEP, 0, 0, 1'b0);
        compare_grid("glider_grid");
        check("glider_gen", generation, 4 * COLS);
`ifdef LIFE_WRAP_EN
        check("glider_live_wrap", live_count, 5);
`else
        check("glider_live_not5", live_count != 5, 1);
`endif

        // Reset in the middle of a sweep.
        issue(STEP, 0, 0);
        repeat (ROWS / 2) begin @(posedge clk); #1; end
        check("midreset_was_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_gen", generation, 0);
        check("midreset_live", live_count, 0);
        check("midreset_ready", cmd_ready, 1);
        diff = 0;
        for (int i = 0; i < ROWS + 2; i++) begin
            if (done !== 1'b0) diff++;
            @(posedge clk); #1;
        end
        check("midreset_no_done", diff, 0);
        compare_grid("midreset_grid");
        do_cmd(SEED, 0, 0, 1'b0);
        compare_grid("seed_after_reset_grid");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/life_engine.md
# life_engine

Parametrised Game-of-Life generation engine: holds a COLS×ROWS cell grid in registers and accepts single-cycle commands from the keyboard decoder. Commands are step, clear, toggle-at-cursor and pseudo-random seed. It computes one generation row-by-row, one row per clock. It also tracks the generation number and live-cell count for the 7-segment display, and serves a registered single-cell read port to the VGA image path.

## Interface
Parameters:
- COLS, 32, grid width in cells (≥3)
- ROWS, 24, grid height in cells (≥3)
- GEN_W, 13, generation counter width
- SEED_INIT, 32'hACE1_2F5B, LFSR reset value (must be non-zero)

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command strobe
- cmd  in  3  0=NOP, 1=STEP, 2=CLEAR, 3=TOGGLE, 4=SEED, 5–7 reserved (treated as NOP)
- cmd_ready  out  1  high when IDLE; a command is accepted when cmd_valid & cmd_ready
- cur_x  in  $clog2(COLS)  toggle column
- cur_y  in  $clog2(ROWS)  toggle row
- rd_x  in  $clog2(COLS)  read column
- rd_y  in  $clog2(ROWS)  read row
- rd_cell  out  1  registered cell value at (rd_x, rd_y)
- busy  out  1  STEP or SEED sweep in progress
- done  out  1  one-cycle pulse when a STEP or SEED sweep finishes
- generation  out  GEN_W  generation number
- live_count  out  $clog2(COLS*ROWS+1)  number of live cells

## Operation
- States: IDLE, STEP, SEED. Row counter `row` runs 0..ROWS-1.
- CLEAR and TOGGLE complete in IDLE in one cycle. Neither raises busy or done.
- In STEP and SEED, commands are ignored: cmd_ready is low and nothing is queued.
- Accepting STEP latches old row 0 into `first_old` and enters STEP with row=0.
- Each STEP cycle computes the new row r from three old rows:
  - above: old row ROWS-1 when r=0, otherwise `prev_old`
  - centre: the current row r
  - below: current row r+1, or `first_old` when r=ROWS-1
- Each STEP cycle then writes row r, saves old row r into `prev_old`, and adds popcount(new row) to an accumulator.
- Rule: a live cell stays live with 2 or 3 neighbours. A dead cell becomes live with exactly 3. Neighbour counts are 4-bit.
- Horizontal and vertical edge behaviour is set by the configuration macro.
- Final STEP cycle (r=ROWS-1): generation += 1, wrapping from 2^GEN_W−1 to 0. live_count takes the accumulator plus the final row's popcount. Return to IDLE.
- SEED: each cycle writes row r with bit c = lfsr[c mod 32], then advances the LFSR one Galois step (x^32+x^22+x^2+x+1). The LFSR is not reset by CLEAR.
- Final SEED cycle: generation=0, live_count=popcount total, return to IDLE.
- CLEAR: zero the grid, generation=0, live_count=0.
- TOGGLE:
  - Inverts the cell at (cur_x, cur_y). live_count is incremented if the cell becomes live, decremented if it becomes dead.
  - Out-of-range coordinates are ignored; nothing changes.
  - generation is unchanged.
- Read port:
  - rd_cell reflects the grid as it stood at the sampling edge.
  - During STEP it may show a partially updated generation; this is permitted.
  - Out-of-range coordinates return 0.

## Timing
- Reset values: grid all 0, rd_cell=0, busy=0, done=0, generation=0, live_count=0, LFSR=SEED_INIT, state IDLE, cmd_ready=1.
- STEP or SEED accepted at edge k:
  - busy=1 and cmd_ready=0 for cycles k+1..k+ROWS
  - at edge k+ROWS the final row is written
  - in the cycle after edge k+ROWS: busy=0, done=1, new generation and live_count visible
  - cmd_ready=1 again, so back-to-back STEP is possible with one idle cycle
- CLEAR or TOGGLE accepted at edge k: the grid and counters are updated after edge k.
- rd_cell latency: 1 cycle.
- rst asserted mid-sweep: the next edge forces reset values. The partial grid is discarded (zeroed) and done is not pulsed.

## Configuration
- LIFE_WRAP_EN defined: the grid is toroidal. Column −1 maps to COLS−1 and column COLS maps to 0; rows use the same wrap via the above/below selection.
- LIFE_WRAP_EN undefined: cells beyond the border read as dead. The above row is zero when r=0, the below row is zero when r=ROWS−1, and edge columns get zero neighbours outside the grid. `first_old` is unused.

## Test plan
- Reset, then read all cells → rd_cell=0 everywhere, generation=0, live_count=0, cmd_ready=1.
- TOGGLE (4,5),(5,5),(6,5) then STEP → row 5 cleared and column 5 rows 4–6 live. live_count=3, generation=1, done pulses exactly at cycle k+ROWS+1. A second STEP restores the horizontal blinker with generation=2.
- Glider at the top-left corner, 4·COLS STEPs:
  - with LIFE_WRAP_EN: live_count stays 5 and the pattern returns translated
  - without it: the glider hits the border and live_count ≠5 (becomes a 4-cell block)
- STEP accepted, then CLEAR and TOGGLE issued during busy → both ignored. Grid equals a pure single-step result.
- SEED → live_count equals the bench-model popcount of the LFSR rows and generation=0. CLEAR afterwards → live_count=0. A second SEED gives a different pattern (LFSR not reset).
- rst asserted at row ROWS/2 of a STEP → next cycle busy=0, grid zero, generation=0, no done pulse.
